// File: rtl/jump_unit_ras.sv
// jump_unit_ras: EX-stage resolver for JAL/JALR with a circular return-address
// stack. Computes target and link, decides rd writeback, applies RAS push/pop
// hints and reports whether the RAS prediction matched a resolved return.
// A single registered output stage hands results to MEM.
//
// Handshake (both sides): a transfer happens on a rising clk edge where valid
// and ready are both high. in_ready = (!out_valid | out_ready) & !flush. While
// out_valid & !out_ready the output fields are held stable. flush drops the
// held result and blocks acceptance for that cycle.
module jump_unit_ras #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 8,
  parameter int C_EXT     = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   in_op,
  input  logic [XLEN-1:0]              in_pc,
  input  logic [XLEN-1:0]              in_rs1_val,
  input  logic [XLEN-1:0]              in_imm,
  input  logic [4:0]                   in_rd,
  input  logic [4:0]                   in_rs1,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [XLEN-1:0]              out_target,
  output logic [XLEN-1:0]              out_link,
  output logic [4:0]                   out_rd,
  output logic                         out_wen,
  output logic                         out_misalign,
  output logic                         out_illegal,
  output logic [XLEN-1:0]              out_ras_pred,
  output logic                         out_ras_hit,
  output logic [$clog2(RAS_DEPTH):0]   ras_count
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  // Return-address stack storage and bookkeeping.
  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   ras_ptr;
  logic [PW-1:0]   ptr_m1;

  // Decoded request.
  logic            op_jal;
  logic            op_jalr;
  logic            legal;
  logic [XLEN-1:0] sum_jal;
  logic [XLEN-1:0] sum_jalr;
  logic [XLEN-1:0] target_c;
  logic [XLEN-1:0] link_c;
  logic            misalign_c;
  logic            wen_c;
  logic            rd_link;
  logic            rs1_link;
  logic            push_h;
  logic            pop_h;
  logic            accept;
  logic            upd_ok;
  logic            do_push;
  logic            do_pop;
  logic [XLEN-1:0] pred_c;
  logic            hit_c;

  assign in_ready = (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign ptr_m1   = ras_ptr - PW'(1);

  // Target/link arithmetic, misalignment and writeback decision.
  always_comb begin
    op_jal     = (in_op == 2'd0);
    op_jalr    = (in_op == 2'd1);
    legal      = op_jal || op_jalr;
    sum_jal    = in_pc + in_imm;
    sum_jalr   = (in_rs1_val + in_imm) & ~XLEN'(1);
    target_c   = '0;
    link_c     = '0;
    if (legal) begin
      target_c = op_jal ? sum_jal : sum_jalr;
      link_c   = in_pc + XLEN'(4);
    end
    // With compressed instructions every 2-byte aligned target is legal.
    misalign_c = (C_EXT == 0) ? target_c[1] : 1'b0;
    wen_c      = legal && !misalign_c && (in_rd != 5'd0);
  end

  // RAS hint decode: x1 and x5 are the link registers.
  always_comb begin
    rd_link  = (in_rd == 5'd1) || (in_rd == 5'd5);
    rs1_link = (in_rs1 == 5'd1) || (in_rs1 == 5'd5);
    push_h   = 1'b0;
    pop_h    = 1'b0;
    if (op_jal) begin
      push_h = rd_link;
    end else if (op_jalr) begin
      push_h = rd_link;
      // Pop unless both are link registers and identical (that case is a call).
      pop_h  = rs1_link && (!rd_link || (in_rd != in_rs1));
    end
  end

  // Qualify hints with acceptance; a pop from an empty stack is a no-op.
  always_comb begin
    upd_ok  = accept && legal && !misalign_c;
    do_push = upd_ok && push_h;
    do_pop  = upd_ok && pop_h && (ras_count != '0);
    pred_c  = do_pop ? ras_mem[ptr_m1] : '0;
    hit_c   = do_pop && (pred_c == target_c);
  end

  // RAS state update; pop+push replaces the top entry in place.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ras_ptr   <= '0;
      ras_count <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
    end else if (do_pop && do_push) begin
      ras_mem[ptr_m1] <= link_c;
    end else if (do_push) begin
      ras_mem[ras_ptr] <= link_c;
      ras_ptr          <= ras_ptr + PW'(1);
      // Saturating count: overflow overwrites the oldest entry silently.
      if (ras_count != FULL) ras_count <= ras_count + CW'(1);
    end else if (do_pop) begin
      ras_ptr   <= ptr_m1;
      ras_count <= ras_count - CW'(1);
    end
  end

  // Output stage: capture on accept, drop on flush, retire when drained.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_target   <= '0;
      out_link     <= '0;
      out_rd       <= '0;
      out_wen      <= 1'b0;
      out_misalign <= 1'b0;
      out_illegal  <= 1'b0;
      out_ras_pred <= '0;
      out_ras_hit  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_target   <= target_c;
      out_link     <= link_c;
      out_rd       <= in_rd;
      out_wen      <= wen_c;
      out_misalign <= misalign_c;
      out_illegal  <= !legal;
      out_ras_pred <= pred_c;
      out_ras_hit  <= hit_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jump_unit_ras.sv
// tb_jump_unit_ras: directed bench for jump_unit_ras. A second instance with
// compressed ISA enabled shares the inputs to cover 2-byte alignment.
module tb_jump_unit_ras;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic [1:0]      in_op;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_rs1_val;
  logic [XLEN-1:0] in_imm;
  logic [4:0]      in_rd;
  logic [4:0]      in_rs1;
  logic            out_ready;

  logic            in_ready, out_valid, out_wen, out_misalign, out_illegal, out_ras_hit;
  logic [XLEN-1:0] out_target, out_link, out_ras_pred;
  logic [4:0]      out_rd;
  logic [3:0]      ras_count;

  logic            in_ready_c, out_valid_c, out_wen_c, out_misalign_c, out_illegal_c, out_ras_hit_c;
  logic [XLEN-1:0] out_target_c, out_link_c, out_ras_pred_c;
  logic [4:0]      out_rd_c;
  logic [3:0]      ras_count_c;

  int checks = 0;
  int errors = 0;

  jump_unit_ras #(.XLEN(XLEN), .RAS_DEPTH(8), .C_EXT(0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_pc(in_pc), .in_rs1_val(in_rs1_val), .in_imm(in_imm),
    .in_rd(in_rd), .in_rs1(in_rs1), .out_valid(out_valid), .out_ready(out_ready),
    .out_target(out_target), .out_link(out_link), .out_rd(out_rd), .out_wen(out_wen),
    .out_misalign(out_misalign), .out_illegal(out_illegal), .out_ras_pred(out_ras_pred),
    .out_ras_hit(out_ras_hit), .ras_count(ras_count)
  );

  jump_unit_ras #(.XLEN(XLEN), .RAS_DEPTH(8), .C_EXT(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_c),
    .in_op(in_op), .in_pc(in_pc), .in_rs1_val(in_rs1_val), .in_imm(in_imm),
    .in_rd(in_rd), .in_rs1(in_rs1), .out_valid(out_valid_c), .out_ready(out_ready),
    .out_target(out_target_c), .out_link(out_link_c), .out_rd(out_rd_c), .out_wen(out_wen_c),
    .out_misalign(out_misalign_c), .out_illegal(out_illegal_c), .out_ras_pred(out_ras_pred_c),
    .out_ras_hit(out_ras_hit_c), .ras_count(ras_count_c)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Driver: present one request at the falling edge, hold across one rising
  // edge, then drop in_valid 1 time unit after that edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] pc, input logic [31:0] rs1v,
                       input logic [31:0] imm, input logic [4:0] rd, input logic [4:0] rs1);
    @(negedge clk);
    in_op = op; in_pc = pc; in_rs1_val = rs1v; in_imm = imm; in_rd = rd; in_rs1 = rs1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_target !== 32'h0) begin errors++; $display("FAIL reset_target: got %h expected 0", out_target); end
    checks++; if (out_link !== 32'h0) begin errors++; $display("FAIL reset_link: got %h expected 0", out_link); end
    checks++; if (ras_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", ras_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_jal_ret();
    issue(2'd0, 32'h100, 32'h0, 32'h20, 5'd1, 5'd0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL jal_valid: got %b expected 1", out_valid); end
    checks++; if (out_target !== 32'h120) begin errors++; $display("FAIL jal_target: got %h expected 120", out_target); end
    checks++; if (out_link !== 32'h104) begin errors++; $display("FAIL jal_link: got %h expected 104", out_link); end
    checks++; if (out_wen !== 1'b1) begin errors++; $display("FAIL jal_wen: got %b expected 1", out_wen); end
    checks++; if (out_rd !== 5'd1) begin errors++; $display("FAIL jal_rd: got %0d expected 1", out_rd); end
    checks++; if (ras_count !== 4'd1) begin errors++; $display("FAIL jal_count: got %0d expected 1", ras_count); end
    checks++; if (out_ras_hit !== 1'b0) begin errors++; $display("FAIL jal_hit: got %b expected 0", out_ras_hit); end
    issue(2'd1, 32'h200, 32'h104, 32'h0, 5'd0, 5'd1);
    checks++; if (out_target !== 32'h104) begin errors++; $display("FAIL ret_target: got %h expected 104", out_target); end
    checks++; if (out_ras_pred !== 32'h104) begin errors++; $display("FAIL ret_pred: got %h expected 104", out_ras_pred); end
    checks++; if (out_ras_hit !== 1'b1) begin errors++; $display("FAIL ret_hit: got %b expected 1", out_ras_hit); end
    checks++; if (out_wen !== 1'b0) begin errors++; $display("FAIL ret_wen: got %b expected 0", out_wen); end
    checks++; if (ras_count !== 4'd0) begin errors++; $display("FAIL ret_count: got %0d expected 0", ras_count); end
  endtask

  // rd=x1 makes this a push hint; misalignment must suppress it on dut only.
  task automatic test_misalign();
    issue(2'd1, 32'h300, 32'h203, 32'h0, 5'd1, 5'd3);
    checks++; if (out_target !== 32'h202) begin errors++; $display("FAIL mis_target: got %h expected 202", out_target); end
    checks++; if (out_misalign !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b expected 1", out_misalign); end
    checks++; if (out_wen !== 1'b0) begin errors++; $display("FAIL mis_wen: got %b expected 0", out_wen); end
    checks++; if (ras_count !== 4'd0) begin errors++; $display("FAIL mis_count: got %0d expected 0", ras_count); end
    checks++; if (out_misalign_c !== 1'b0) begin errors++; $display("FAIL mis_c_flag: got %b expected 0", out_misalign_c); end
    checks++; if (out_wen_c !== 1'b1) begin errors++; $display("FAIL mis_c_wen: got %b expected 1", out_wen_c); end
    checks++; if (ras_count_c !== 4'd1) begin errors++; $display("FAIL mis_c_count: got %0d expected 1", ras_count_c); end
    checks++; if (out_target_c !== 32'h202) begin errors++; $display("FAIL mis_c_target: got %h expected 202", out_target_c); end
  endtask

  task automatic test_overflow();
    logic [31:0] pc;
    apply_reset();
    for (int i = 1; i <= 9; i++) begin
      pc = 32'h1000 + 32'(i) * 32'h10;
      issue(2'd0, pc, 32'h0, 32'h40, 5'd1, 5'd0);
    end
    checks++; if (ras_count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d expected 8", ras_count); end
    for (int i = 9; i >= 2; i--) begin
      pc = 32'h1000 + 32'(i) * 32'h10 + 32'h4;
      issue(2'd1, 32'h2000, pc, 32'h0, 5'd0, 5'd1);
      checks++; if (out_ras_pred !== pc) begin errors++; $display("FAIL ovf_pred%0d: got %h expected %h", i, out_ras_pred, pc); end
      checks++; if (out_ras_hit !== 1'b1) begin errors++; $display("FAIL ovf_hit%0d: got %b expected 1", i, out_ras_hit); end
    end
    checks++; if (ras_count !== 4'd0) begin errors++; $display("FAIL ovf_drained: got %0d expected 0", ras_count); end
    issue(2'd1, 32'h2000, 32'h50, 32'h0, 5'd0, 5'd1);
    checks++; if (out_ras_pred !== 32'h0) begin errors++; $display("FAIL empty_pred: got %h expected 0", out_ras_pred); end
    checks++; if (out_ras_hit !== 1'b0) begin errors++; $display("FAIL empty_hit: got %b expected 0", out_ras_hit); end
    checks++; if (ras_count !== 4'd0) begin errors++; $display("FAIL empty_count: got %0d expected 0", ras_count); end
  endtask

  task automatic test_stall_flush();
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b expected 0", out_valid); end
    out_ready = 1'b0;
    issue(2'd0, 32'h300, 32'h0, 32'h10, 5'd1, 5'd0);
    checks++; if (ras_count !== 4'd1) begin errors++; $display("FAIL stall_push: got %0d expected 1", ras_count); end
    @(negedge clk);
    in_op = 2'd0; in_pc = 32'h400; in_imm = 32'h8; in_rd = 5'd5; in_rs1 = 5'd0;
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready%0d: got %b expected 0", c, in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid%0d: got %b expected 1", c, out_valid); end
      checks++; if (out_target !== 32'h310) begin errors++; $display("FAIL stall_target%0d: got %h expected 310", c, out_target); end
      checks++; if (out_link !== 32'h304) begin errors++; $display("FAIL stall_link%0d: got %h expected 304", c, out_link); end
      checks++; if (ras_count !== 4'd1) begin errors++; $display("FAIL stall_count%0d: got %0d expected 1", c, ras_count); end
    end
    @(negedge clk);
    flush = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
    checks++; if (ras_count !== 4'd1) begin errors++; $display("FAIL flush_count: got %0d expected 1", ras_count); end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_wrap_illegal();
    issue(2'd0, 32'hFFFF_FFFC, 32'h0, 32'h8, 5'd3, 5'd0);
    checks++; if (out_target !== 32'h4) begin errors++; $display("FAIL wrap_target: got %h expected 4", out_target); end
    checks++; if (out_link !== 32'h0) begin errors++; $display("FAIL wrap_link: got %h expected 0", out_link); end
    checks++; if (out_wen !== 1'b1) begin errors++; $display("FAIL wrap_wen: got %b expected 1", out_wen); end
    issue(2'd3, 32'h500, 32'h0, 32'h10, 5'd1, 5'd0);
    checks++; if (out_illegal !== 1'b1) begin errors++; $display("FAIL ill_flag: got %b expected 1", out_illegal); end
    checks++; if (out_wen !== 1'b0) begin errors++; $display("FAIL ill_wen: got %b expected 0", out_wen); end
    checks++; if (out_target !== 32'h0) begin errors++; $display("FAIL ill_target: got %h expected 0", out_target); end
    checks++; if (out_link !== 32'h0) begin errors++; $display("FAIL ill_link: got %h expected 0", out_link); end
    checks++; if (ras_count !== 4'd1) begin errors++; $display("FAIL ill_count: got %0d expected 1", ras_count); end
  endtask

  // Consecutive accepts; stack holds 0x304 on entry.
  task automatic test_back_to_back();
    issue(2'd0, 32'h500, 32'h0, 32'h4, 5'd1, 5'd0);
    checks++; if (ras_count !== 4'd2) begin errors++; $display("FAIL b2b_push: got %0d expected 2", ras_count); end
    issue(2'd1, 32'h580, 32'h504, 32'h0, 5'd0, 5'd1);
    checks++; if (out_ras_pred !== 32'h504) begin errors++; $display("FAIL b2b_pred: got %h expected 504", out_ras_pred); end
    checks++; if (out_ras_hit !== 1'b1) begin errors++; $display("FAIL b2b_hit: got %b expected 1", out_ras_hit); end
    issue(2'd0, 32'h600, 32'h0, 32'h40, 5'd1, 5'd0);
    issue(2'd1, 32'h700, 32'h604, 32'h0, 5'd5, 5'd1);
    checks++; if (out_ras_pred !== 32'h604) begin errors++; $display("FAIL swap_pred: got %h expected 604", out_ras_pred); end
    checks++; if (out_ras_hit !== 1'b1) begin errors++; $display("FAIL swap_hit: got %b expected 1", out_ras_hit); end
    checks++; if (ras_count !== 4'd2) begin errors++; $display("FAIL swap_count: got %0d expected 2", ras_count); end
    issue(2'd1, 32'h800, 32'h704, 32'h0, 5'd0, 5'd5);
    checks++; if (out_ras_pred !== 32'h704) begin errors++; $display("FAIL swap_top: got %h expected 704", out_ras_pred); end
    checks++; if (ras_count !== 4'd1) begin errors++; $display("FAIL swap_pop_count: got %0d expected 1", ras_count); end
    issue(2'd1, 32'h900, 32'h998, 32'h0, 5'd0, 5'd1);
    checks++; if (out_ras_pred !== 32'h304) begin errors++; $display("FAIL miss_pred: got %h expected 304", out_ras_pred); end
    checks++; if (out_ras_hit !== 1'b0) begin errors++; $display("FAIL miss_hit: got %b expected 0", out_ras_hit); end
    checks++; if (ras_count !== 4'd0) begin errors++; $display("FAIL miss_count: got %0d expected 0", ras_count); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    issue(2'd0, 32'hA00, 32'h0, 32'h20, 5'd1, 5'd0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b expected 1", out_valid); end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", out_valid); end
    checks++; if (out_target !== 32'h0) begin errors++; $display("FAIL mid_target: got %h expected 0", out_target); end
    checks++; if (out_link !== 32'h0) begin errors++; $display("FAIL mid_link: got %h expected 0", out_link); end
    checks++; if (out_wen !== 1'b0) begin errors++; $display("FAIL mid_wen: got %b expected 0", out_wen); end
    checks++; if (ras_count !== 4'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", ras_count); end
    rst_n = 1'b1;
    out_ready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = 2'd0; in_pc = '0; in_rs1_val = '0; in_imm = '0; in_rd = '0; in_rs1 = '0;
    test_reset();
    test_jal_ret();
    test_misalign();
    test_overflow();
    test_stall_flush();
    test_wrap_illegal();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jump_unit_ras.md
Name: jump_unit_ras

Overview:
- Parametrised, pipelined successor to the EX-stage JAL adder.
- Resolves JAL and JALR: computes the target and the link value (PC+4) and decides the rd writeback.
- Maintains a circular return-address stack (RAS) using the RISC-V push/pop hints, and reports whether the RAS prediction for a return matched the resolved JALR target.
- One registered output stage with a valid/ready handshake toward MEM.

Parameters:
- XLEN, 32: datapath width.
- RAS_DEPTH, 8: number of RAS entries; power of two, at least 2.
- C_EXT, 0: 1 = compressed ISA enabled (2-byte alignment); 0 = 4-byte alignment.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  kill the output stage and block acceptance this cycle
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept
- in_op  in  2  0=JAL, 1=JALR, 2/3=illegal
- in_pc  in  XLEN  PC of the instruction
- in_rs1_val  in  XLEN  rs1 operand (JALR)
- in_imm  in  XLEN  sign-extended offset
- in_rd  in  5  destination register index
- in_rs1  in  5  rs1 register index
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_target  out  XLEN  resolved jump address
- out_link  out  XLEN  in_pc+4
- out_rd  out  5  destination index
- out_wen  out  1  write out_link to rd
- out_misalign  out  1  target-misaligned exception
- out_illegal  out  1  illegal op
- out_ras_pred  out  XLEN  popped RAS value (0 if no pop)
- out_ras_hit  out  1  pop occurred and out_ras_pred==out_target
- ras_count  out  clog2(RAS_DEPTH)+1  valid RAS entries

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All outputs and registers are 0; out_valid=0; RAS pointer and count are 0.
  - Reset mid-transfer drops the held result.
- Handshake:
  - in_ready = !out_valid | out_ready. Combinational; in_ready=0 while flush=1.
  - Accept when in_valid & in_ready & !flush. Result is registered with latency 1: out_valid rises on the next edge.
  - out_valid clears on an edge where out_ready=1 and nothing is accepted.
  - Output fields stay stable while out_valid & !out_ready.
- Flush: on an edge with flush=1, out_valid←0 and no input is accepted. RAS contents are untouched.
- Arithmetic, all modulo 2^XLEN (wrap-around, no overflow flag):
  - JAL: target = in_pc + in_imm.
  - JALR: target = (in_rs1_val + in_imm) with bit 0 forced to 0.
  - link = in_pc + 4.
- Misalign:
  - C_EXT=0: out_misalign = target[1].
  - C_EXT=1: out_misalign = 0 (bit 0 is always 0 for JALR, and JAL immediates are even).
- Writeback: out_wen = legal & !misalign & (in_rd != 0).
- Illegal op: out_illegal=1, target=0, link=0, wen=0, no RAS change.
- RAS hints: "link register" means index 1 or 5.
  - JAL: push link if rd is a link register.
  - JALR, by rd/rs1 link status:
    - rd no, rs1 no: none.
    - rd no, rs1 yes: pop.
    - rd yes, rs1 no: push.
    - both yes, rd != rs1: pop then push (replace top with link; count unchanged if non-empty; plain push if empty).
    - both yes, rd == rs1: push.
- RAS update:
  - Happens only on accept of a legal, non-misaligned instruction.
  - Push writes the entry at the pointer, then pointer+1 modulo RAS_DEPTH; count saturates at RAS_DEPTH, so overflow silently overwrites the oldest entry.
  - Pop reads entry pointer-1, then pointer-1 and count-1.
  - Pop when count=0: no state change, out_ras_pred=0, out_ras_hit=0.
  - out_ras_pred and out_ras_hit are registered with the result; out_ras_hit is 0 whenever no pop occurred.
- Back-to-back accepts each see the RAS state left by the previous accept (no bypass hazard, since the update is in the accept cycle).

Test Plan:
- JAL in_pc=0x100, imm=0x20, rd=1 → next cycle out_target=0x120, out_link=0x104, out_wen=1, ras_count=1.
- JALR rs1=1, rd=0, rs1_val=0x104, imm=0 following that JAL → out_target=0x104, out_ras_pred=0x104, out_ras_hit=1, out_wen=0, ras_count=0.
- JALR rs1_val=0x203, imm=0, C_EXT=0, rd=2 → target=0x202, out_misalign=1, out_wen=0, RAS unchanged; same with C_EXT=1 → misalign=0.
- 9 JALs with rd=1 and distinct PCs at RAS_DEPTH=8 → ras_count=8; 8 pops return PCs 9..2 (+4); a 9th pop gives hit=0, pred=0.
- Hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs stable; assert flush → out_valid=0 next edge, input not accepted, ras_count unchanged.
- in_pc=0xFFFFFFFC JAL imm=8 → target=0x4, link=0x0; in_op=3 → out_illegal=1, wen=0; rst_n=0 mid-stream → all outputs 0 next edge.
